// File: rtl/core_loader_pkg.sv
// Shared types and command codes for the host-side core loader.
// CORE_LOADER_CHECKSUM_EN adds the trailing checksum state.
package core_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_COUNT,
      ST_DATA,
      ST_WRITE
`ifdef CORE_LOADER_CHECKSUM_EN
      , ST_CSUM
`endif
   } loader_state_t;

   localparam logic [7:0] CMD_CLEAR   = 8'h00;
   localparam logic [7:0] CMD_WR_INSN = 8'h01;
   localparam logic [7:0] CMD_WR_DATA = 8'h02;
   localparam logic [7:0] CMD_RUN     = 8'h03;
   localparam logic [7:0] CMD_HALT    = 8'h04;

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian byte-to-word assembler shared by the ADDR and DATA fields.
// `word` is the word including the byte currently offered on byte_in.
module loader_word_asm (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_done
);

   logic [1:0]  idx;
   logic [31:0] shift;

   assign word      = {byte_in, shift[31:8]};
   assign word_done = byte_valid && (idx == 2'd3);

   // The index wraps after four bytes, so ADDR and each DATA word start clean.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx   <= 2'd0;
         shift <= 32'd0;
      end else if (clear) begin
         idx   <= 2'd0;
      end else if (byte_valid) begin
         shift <= word;
         idx   <= idx + 2'd1;
      end
   end

endmodule

// File: rtl/core_loader.sv
// Host-link frame decoder that loads core memories and owns the core's run bit.
// Define CORE_LOADER_CHECKSUM_EN to require a trailing XOR checksum on write frames.
module core_loader
   import core_loader_pkg::*;
#(
   parameter int LEN_BYTES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [31:0] insn_addr,
   output logic [31:0] insn_din,
   output logic        insn_we,
   output logic [31:0] data_addr,
   output logic [31:0] data_din,
   output logic        data_we,
   output logic        run,
   output logic        busy,
   output logic        err
);

   localparam int CW = 8 * LEN_BYTES;

`ifdef CORE_LOADER_CHECKSUM_EN
   localparam loader_state_t ST_END = ST_CSUM;
`else
   localparam loader_state_t ST_END = ST_IDLE;
`endif

   loader_state_t state;
   logic          is_data;
   logic [31:0]   cur_addr;
   logic [CW-1:0] count_shift;
   logic [CW-1:0] count_next;
   logic [CW-1:0] words_left;
   logic [7:0]    field_idx;
   logic          accept;
   logic [31:0]   asm_word;
   logic          asm_done;

   assign accept     = rx_valid && rx_ready;
   assign busy       = (state != ST_IDLE);
   assign count_next = (count_shift >> 8) | (CW'(rx_data) << (CW - 8));

   loader_word_asm u_word_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (accept && (state == ST_IDLE)),
      .byte_valid (accept && ((state == ST_ADDR) || (state == ST_DATA))),
      .byte_in    (rx_data),
      .word       (asm_word),
      .word_done  (asm_done)
   );

`ifdef CORE_LOADER_CHECKSUM_EN
   logic [7:0] csum;

   // Running XOR of every byte after CMD; restarted by each command byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         csum <= 8'd0;
      end else if (accept) begin
         csum <= (state == ST_IDLE) ? 8'd0 : (csum ^ rx_data);
      end
   end
`endif

   // Frame decoder; rx_ready is registered so it is low in reset and in WRITE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         rx_ready    <= 1'b0;
         is_data     <= 1'b0;
         cur_addr    <= 32'd0;
         count_shift <= '0;
         words_left  <= '0;
         field_idx   <= 8'd0;
         insn_addr   <= 32'd0;
         insn_din    <= 32'd0;
         insn_we     <= 1'b0;
         data_addr   <= 32'd0;
         data_din    <= 32'd0;
         data_we     <= 1'b0;
         run         <= 1'b0;
         err         <= 1'b0;
      end else begin
         insn_we  <= 1'b0;
         data_we  <= 1'b0;
         rx_ready <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  case (rx_data)
                     CMD_CLEAR: err <= 1'b0;
                     CMD_WR_INSN, CMD_WR_DATA: begin
                        is_data   <= (rx_data == CMD_WR_DATA);
                        run       <= 1'b0;
                        field_idx <= 8'd0;
                        state     <= ST_ADDR;
                     end
                     CMD_RUN:  if (!err) run <= 1'b1;
                     CMD_HALT: run <= 1'b0;
                     default:  err <= 1'b1;
                  endcase
               end
            end
            ST_ADDR: begin
               if (asm_done) begin
                  cur_addr <= asm_word;
                  state    <= ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (accept) begin
                  count_shift <= count_next;
                  field_idx   <= field_idx + 8'd1;
                  if (field_idx == 8'(LEN_BYTES - 1)) begin
                     field_idx  <= 8'd0;
                     words_left <= count_next;
                     state      <= (count_next != '0) ? ST_DATA : ST_END;
                  end
               end
            end
            ST_DATA: begin
               if (asm_done) begin
                  state    <= ST_WRITE;
                  rx_ready <= 1'b0;
                  if (is_data) begin
                     data_we   <= 1'b1;
                     data_addr <= cur_addr;
                     data_din  <= asm_word;
                  end else begin
                     insn_we   <= 1'b1;
                     insn_addr <= cur_addr;
                     insn_din  <= asm_word;
                  end
               end
            end
            ST_WRITE: begin
               cur_addr   <= cur_addr + 32'd4;
               words_left <= words_left - CW'(1);
               state      <= (words_left == CW'(1)) ? ST_END : ST_DATA;
            end
`ifdef CORE_LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (accept) begin
                  if (rx_data != csum) err <= 1'b1;
                  state <= ST_IDLE;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
